// File: rtl/byte_enable_ram_dp_cfg_pkg.sv
// Shared types and helpers for the configurable dual-port byte-enable RAM.
package byte_enable_ram_dp_cfg_pkg;

  // Result returned by a port that writes and reads the same word in one cycle
  typedef enum logic {
    READ_FIRST  = 1'b0,  // pre-write word
    WRITE_FIRST = 1'b1   // word with this port's enabled bytes already merged
  } ram_rw_mode_t;

  // Controller state: zeroing sweep after reset, then normal service
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ram_state_t;

  // Number of byte lanes in a word of the given bit width
  function automatic int bytes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/byte_enable_ram_dp_cfg_read_pipe.sv
// Optional output register chain for one RAM port. Each stage loads its data
// only when the stage before it carries a valid result, so the port output
// keeps the last read word while the port is idle.
module byte_enable_ram_read_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Clock and reset are only needed when there is at least one stage
      logic w_unused_ok;
      assign w_unused_ok = clk ^ rst_n;
      assign o_valid     = i_valid;
      assign o_data      = i_data;
    end else begin : g_stages
      logic                  w_valid [DEPTH+1];
      logic [DATA_WIDTH-1:0] w_data  [DEPTH+1];
      logic                  r_valid [DEPTH];
      logic [DATA_WIDTH-1:0] r_data  [DEPTH];

      assign w_valid[0] = i_valid;
      assign w_data[0]  = i_data;

      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        // One pipeline stage: valid always advances, data advances with valid
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_valid[gi] <= 1'b0;
            r_data[gi]  <= '0;
          end else begin
            r_valid[gi] <= w_valid[gi];
            if (w_valid[gi]) begin
              r_data[gi] <= w_data[gi];
            end
          end
        end

        assign w_valid[gi+1] = r_valid[gi];
        assign w_data[gi+1]  = r_data[gi];
      end

      assign o_valid = w_valid[DEPTH];
      assign o_data  = w_data[DEPTH];
    end
  endgenerate

endmodule

// File: rtl/byte_enable_ram_dp_cfg.sv
// Parametrised true dual-port RAM with per-byte write enables, selectable
// same-port read/write behaviour, optional output register, optional zeroing
// sweep after reset and per-port read-valid strobes. On a same-address,
// same-cycle collision port A owns every byte it enables.
module byte_enable_ram_dp_cfg
  import byte_enable_ram_dp_cfg_pkg::*;
#(
  parameter int           LINES            = 8192,
  parameter int           DATA_WIDTH       = 32,
  parameter int           OUTPUT_REG       = 0,
  parameter ram_rw_mode_t RW_MODE          = READ_FIRST,
  parameter bit           CLEAR_ON_RESET   = 1'b0,
  parameter bit           USE_PRELOAD_FILE = 1'b0,
  parameter string        preload_file     = ""
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(LINES)-1:0]     i_addr_a,
  input  logic                         i_en_a,
  input  logic [DATA_WIDTH/8-1:0]      i_be_a,
  input  logic [DATA_WIDTH-1:0]        i_data_in_a,
  output logic [DATA_WIDTH-1:0]        o_data_out_a,
  output logic                         o_valid_a,
  input  logic [$clog2(LINES)-1:0]     i_addr_b,
  input  logic                         i_en_b,
  input  logic [DATA_WIDTH/8-1:0]      i_be_b,
  input  logic [DATA_WIDTH-1:0]        i_data_in_b,
  output logic [DATA_WIDTH-1:0]        o_data_out_b,
  output logic                         o_valid_b,
  output logic                         o_ready
);

  localparam int             AW        = $clog2(LINES);
  localparam int             NB        = bytes(DATA_WIDTH);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(LINES - 1);

  // The image name only matters when a preload is requested
  localparam bit unused_preload_named = (preload_file != "");

  // ---------------------------------------------------------------------------
  // Configuration sanity
  // ---------------------------------------------------------------------------
  generate
    if (USE_PRELOAD_FILE && CLEAR_ON_RESET) begin : g_bad_preload_cfg
      $error("byte_enable_ram_dp_cfg: preload image and clear-on-reset are mutually exclusive");
    end
    if ((LINES < 2) || ((LINES & (LINES - 1)) != 0)) begin : g_bad_lines
      $error("byte_enable_ram_dp_cfg: LINES must be a power of two and at least 2");
    end
    if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
      $error("byte_enable_ram_dp_cfg: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if ((OUTPUT_REG != 0) && (OUTPUT_REG != 1)) begin : g_bad_outreg
      $error("byte_enable_ram_dp_cfg: OUTPUT_REG must be 0 or 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Clear / run controller
  // ---------------------------------------------------------------------------
  ram_state_t    r_state;
  ram_state_t    w_state_next;
  logic [AW-1:0] r_clear_addr;
  logic          w_ready;
  logic          w_clearing;

  // State register and sweep address; a reset mid-sweep restarts at word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_clear_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_clearing) begin
        r_clear_addr <= r_clear_addr + AW'(1);
      end
    end
  end

  // Next state: leave the sweep once the last word has been zeroed
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_CLEAR: if (r_clear_addr == LAST_ADDR) w_state_next = ST_RUN;
      ST_RUN:   w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  // Controller outputs: requests are only honoured in RUN
  always_comb begin
    w_ready    = 1'b0;
    w_clearing = 1'b0;
    case (r_state)
      ST_CLEAR: w_clearing = 1'b1;
      ST_RUN:   w_ready    = 1'b1;
      default:  w_ready    = 1'b0;
    endcase
  end

  assign o_ready = w_ready;

  // ---------------------------------------------------------------------------
  // Write paths (the sweep borrows port A while clearing)
  // ---------------------------------------------------------------------------
  logic                w_acc_a;
  logic                w_acc_b;
  logic [NB-1:0][7:0]  w_din_a;
  logic [NB-1:0][7:0]  w_din_b;
  logic [AW-1:0]       w_wr_addr_a;
  logic [NB-1:0][7:0]  w_wr_data_a;
  logic [NB-1:0]       w_we_a;
  logic [NB-1:0]       w_we_b;

  assign w_acc_a     = i_en_a & w_ready;
  assign w_acc_b     = i_en_b & w_ready;
  assign w_din_a     = i_data_in_a;
  assign w_din_b     = i_data_in_b;
  assign w_wr_addr_a = w_clearing ? r_clear_addr : i_addr_a;
  assign w_wr_data_a = w_clearing ? '0 : w_din_a;
  assign w_we_a      = w_clearing ? '1 : (w_acc_a ? i_be_a : '0);
  assign w_we_b      = w_acc_b ? i_be_b : '0;

  // ---------------------------------------------------------------------------
  // Storage, organised as byte lanes so each lane maps onto a byte-write enable
  // ---------------------------------------------------------------------------
  logic [NB-1:0][7:0] r_mem [LINES];

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
      // Byte-lane write; port A is applied last so it wins a shared byte
      always_ff @(posedge clk) begin
        if (w_we_b[gi]) begin
          r_mem[i_addr_b][gi] <= w_din_b[gi];
        end
        if (w_we_a[gi]) begin
          r_mem[w_wr_addr_a][gi] <= w_wr_data_a[gi];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read word selection: WRITE_FIRST forwards only this port's own bytes; the
  // other port's concurrent write is never visible in the same cycle
  // ---------------------------------------------------------------------------
  logic [NB-1:0][7:0] w_rd_word_a;
  logic [NB-1:0][7:0] w_rd_word_b;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_rd_merge
      assign w_rd_word_a[gi] = ((RW_MODE == WRITE_FIRST) && i_be_a[gi]) ?
                               w_din_a[gi] : r_mem[i_addr_a][gi];
      assign w_rd_word_b[gi] = ((RW_MODE == WRITE_FIRST) && i_be_b[gi]) ?
                               w_din_b[gi] : r_mem[i_addr_b][gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // First read stage: capture on accepted access, hold while idle
  // ---------------------------------------------------------------------------
  logic                  r_rd_valid_a;
  logic                  r_rd_valid_b;
  logic [DATA_WIDTH-1:0] r_rd_data_a;
  logic [DATA_WIDTH-1:0] r_rd_data_b;

  // Registered read for both ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid_a <= 1'b0;
      r_rd_valid_b <= 1'b0;
      r_rd_data_a  <= '0;
      r_rd_data_b  <= '0;
    end else begin
      r_rd_valid_a <= w_acc_a;
      r_rd_valid_b <= w_acc_b;
      if (w_acc_a) begin
        r_rd_data_a <= w_rd_word_a;
      end
      if (w_acc_b) begin
        r_rd_data_b <= w_rd_word_b;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional output register per port
  // ---------------------------------------------------------------------------
  byte_enable_ram_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OUTPUT_REG)
  ) u_pipe_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_rd_valid_a),
    .i_data  (r_rd_data_a),
    .o_valid (o_valid_a),
    .o_data  (o_data_out_a)
  );

  byte_enable_ram_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OUTPUT_REG)
  ) u_pipe_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_rd_valid_b),
    .i_data  (r_rd_data_b),
    .o_valid (o_valid_b),
    .o_data  (o_data_out_b)
  );

endmodule

// File: tb/tb_byte_enable_ram_dp_cfg.sv
// Scoreboard bench: two RAM instances share one stimulus stream.
// u_dut0: READ_FIRST, OUTPUT_REG=0; u_dut1: WRITE_FIRST, OUTPUT_REG=1.
// Both run the clear sweep on reset (LINES=16, 32-bit words).
module tb_byte_enable_ram_dp_cfg;
  import byte_enable_ram_dp_cfg_pkg::*;

  localparam int LINES = 16;
  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam int AW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b1;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic          en_a = 1'b0, en_b = 1'b0;
  logic [NB-1:0] be_a = '0, be_b = '0;
  logic [DW-1:0] din_a = '0, din_b = '0;

  logic [DW-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic          val_a0, val_b0, val_a1, val_b1;
  logic          rdy0, rdy1;

  byte_enable_ram_dp_cfg #(
    .LINES(LINES), .DATA_WIDTH(DW), .OUTPUT_REG(0), .RW_MODE(READ_FIRST),
    .CLEAR_ON_RESET(1'b1), .USE_PRELOAD_FILE(1'b0), .preload_file("")
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_addr_a(addr_a), .i_en_a(en_a), .i_be_a(be_a), .i_data_in_a(din_a),
    .o_data_out_a(dout_a0), .o_valid_a(val_a0),
    .i_addr_b(addr_b), .i_en_b(en_b), .i_be_b(be_b), .i_data_in_b(din_b),
    .o_data_out_b(dout_b0), .o_valid_b(val_b0),
    .o_ready(rdy0)
  );

  byte_enable_ram_dp_cfg #(
    .LINES(LINES), .DATA_WIDTH(DW), .OUTPUT_REG(1), .RW_MODE(WRITE_FIRST),
    .CLEAR_ON_RESET(1'b1), .USE_PRELOAD_FILE(1'b0), .preload_file("")
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_addr_a(addr_a), .i_en_a(en_a), .i_be_a(be_a), .i_data_in_a(din_a),
    .o_data_out_a(dout_a1), .o_valid_a(val_a1),
    .i_addr_b(addr_b), .i_en_b(en_b), .i_be_b(be_b), .i_data_in_b(din_b),
    .o_data_out_b(dout_b1), .o_valid_b(val_b1),
    .o_ready(rdy1)
  );

  // Scoreboard: index 0=A/dut0, 1=B/dut0, 2=A/dut1, 3=B/dut1
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q [4][$];
  logic [31:0] last_data [4];
  int          lat_req [4] = '{1, 1, 2, 2};
  string       pname [4]   = '{"a0", "b0", "a1", "b1"};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] m_mem [LINES];
  int          m_sweep  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  // Monitor for one port: pop on valid, otherwise the output must hold
  task automatic mon_port(input int p, input logic v, input logic [31:0] d);
    exp_t e;
    if (v === 1'b1) begin
      if (q[p].size() == 0) begin
        check({"unexpected_valid_", pname[p]}, 32'(v), 32'd0);
      end else begin
        e = q[p].pop_front();
        check({"data_", pname[p]}, d, e.data);
        check({"latency_", pname[p]}, 32'(cyc - e.cyc), 32'(lat_req[p]));
        last_data[p] = e.data;
        $display("txn %s: data 0x%08h required 0x%08h latency %0d", pname[p], d, e.data, cyc - e.cyc);
      end
    end else begin
      check({"valid_low_", pname[p]}, 32'(v), 32'd0);
      check({"hold_", pname[p]}, d, last_data[p]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_port(0, val_a0, dout_a0);
      mon_port(1, val_b0, dout_b0);
      mon_port(2, val_a1, dout_a1);
      mon_port(3, val_b1, dout_b1);
    end
  end

  // One cycle of stimulus, entered and left #1 after a rising edge.
  // With hand=1 the supplied hand-computed words are queued instead of the model's.
  task automatic step(input logic ea, input logic [3:0] aa, input logic [3:0] ba, input logic [31:0] da,
                      input logic eb, input logic [3:0] ab, input logic [3:0] bb, input logic [31:0] db,
                      input bit hand, input logic [31:0] h_a_rf, input logic [31:0] h_a_wf,
                      input logic [31:0] h_b_rf, input logic [31:0] h_b_wf);
    logic rdy;
    exp_t e;
    rdy = (m_sweep == 0);
    check("ready_dut0", 32'(rdy0), 32'(rdy));
    check("ready_dut1", 32'(rdy1), 32'(rdy));
    en_a = ea; addr_a = aa; be_a = ba; din_a = da;
    en_b = eb; addr_b = ab; be_b = bb; din_b = db;
    e.cyc = cyc;
    if (ea && rdy) begin
      e.data = hand ? h_a_rf : m_mem[aa];                   q[0].push_back(e);
      e.data = hand ? h_a_wf : merge(m_mem[aa], da, ba);    q[2].push_back(e);
    end
    if (eb && rdy) begin
      e.data = hand ? h_b_rf : m_mem[ab];                   q[1].push_back(e);
      e.data = hand ? h_b_wf : merge(m_mem[ab], db, bb);    q[3].push_back(e);
    end
    if (eb && rdy) m_mem[ab] = merge(m_mem[ab], db, bb);
    if (ea && rdy) m_mem[aa] = merge(m_mem[aa], da, ba);
    @(posedge clk); #1;
    if (m_sweep > 0) m_sweep--;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd_a(input logic [3:0] a, input logic [31:0] req);
    step(1, a, 4'h0, 32'h0, 0, 0, 0, 0, 1, req, req, 0, 0);
  endtask

  task automatic rd_b(input logic [3:0] a, input logic [31:0] req);
    step(0, 0, 0, 0, 1, a, 4'h0, 32'h0, 1, 0, 0, req, req);
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    step(1, a, be, d, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Wait (bounded) until every queued response has been seen
  task automatic drain();
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && n < 20) begin
      idle(1);
      n++;
    end
    check("drain_pending", 32'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 32'd0);
  endtask

  // Assert reset (entered #1 after a rising edge), hold, check outputs, release
  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    en_a = 0; en_b = 0; be_a = '0; be_b = '0;
    for (int p = 0; p < 4; p++) last_data[p] = '0;
    repeat (hold) @(posedge clk);
    #1;
    check("rst_dout_a0", dout_a0, 0); check("rst_valid_a0", 32'(val_a0), 0);
    check("rst_dout_b1", dout_b1, 0); check("rst_valid_b1", 32'(val_b1), 0);
    check("rst_ready0", 32'(rdy0), 0); check("rst_ready1", 32'(rdy1), 0);
    rst_n = 1'b1;
    m_sweep = LINES;
    for (int i = 0; i < LINES; i++) m_mem[i] = '0;
    $display("txn reset: released after %0d cycles", hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    // Test 1: sweep after reset, then an untouched word reads as zero
    do_reset(3);
    mon_en = 1'b1;
    idle(16);
    rd_a(4'd5, 32'h0000_0000);

    // Test 2: partial byte write over an existing word
    wr_a(4'd3, 4'b1111, 32'h1122_3344);
    wr_a(4'd3, 4'b0101, 32'hAABB_CCDD);
    rd_a(4'd3, 32'h11BB_33DD);
    rd_b(4'd3, 32'h11BB_33DD);
    idle(2);

    // Test 3: same-cycle collision on word 7, A wins shared bytes
    wr_a(4'd7, 4'b1111, 32'h5566_7788);
    step(1, 4'd7, 4'b1111, 32'h0000_00FF, 1, 4'd7, 4'b0011, 32'hFFFF_FFFF,
         1, 32'h5566_7788, 32'h0000_00FF, 32'h5566_7788, 32'h5566_FFFF);
    rd_a(4'd7, 32'h0000_00FF);
    // B reads the word A writes in the same cycle: pre-write data on both modes
    step(1, 4'd7, 4'b1000, 32'hCAFE_BABE, 1, 4'd7, 4'b0000, 32'h0,
         1, 32'h0000_00FF, 32'hCA00_00FF, 32'h0000_00FF, 32'h0000_00FF);
    rd_b(4'd7, 32'hCA00_00FF);

    // Test 4: same-port write+read of a zero word
    step(1, 4'd9, 4'b1111, 32'h1234_5678, 0, 0, 0, 0,
         1, 32'h0000_0000, 32'h1234_5678, 0, 0);
    rd_a(4'd9, 32'h1234_5678);
    rd_b(4'd9, 32'h1234_5678);
    drain();

    // Randomised two-port traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
           0, 0, 0, 0, 0);
    end
    drain();

    // Test 5: reset at sweep cycle 8 restarts the full sweep
    do_reset(2);
    idle(8);
    #0;
    do_reset(2);
    // Test 6: requests during the sweep are dropped (no valid, no write)
    for (int i = 0; i < LINES; i++) begin
      step(1, 4'd2, 4'b1111, 32'hDEAD_BEEF, 1, 4'd12, 4'b1111, 32'hFEED_F00D, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < LINES; i++) begin
      step(1, 4'(i), 4'b0000, 32'h0, 1, 4'(LINES - 1 - i), 4'b0000, 32'h0,
           1, 32'h0, 32'h0, 32'h0, 32'h0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
